// File: rtl/smiley_hit_detect.sv
// smiley_hit_detect: finds pixels where the smiley and a brick are both drawn,
// classifies each hit by smiley edge band, OR-accumulates over a frame and
// publishes the result at start of frame, holding it for the whole next frame.
module smiley_hit_detect #(
    parameter int OBJECT_WIDTH_X = 64,
    parameter int OBJECT_HIGHT_Y = 64,
    parameter int EDGE_MARGIN    = 4,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int CNT_W          = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               smileyDR,
    input  logic               brickDR,
    output logic               collision,
    output logic [3:0]         HitEdgeCode,
    output logic [CNT_W-1:0]   hitCount,
    output logic               collisionPulse
);

    localparam logic [11:0]        SCR_W_L = 12'(SCREEN_W);
    localparam logic [11:0]        SCR_H_L = 12'(SCREEN_H);
    localparam logic signed [12:0] OBJ_W_L = 13'(OBJECT_WIDTH_X);
    localparam logic signed [12:0] OBJ_H_L = 13'(OBJECT_HIGHT_Y);
    localparam logic signed [12:0] MARG_L  = 13'(EDGE_MARGIN);
    localparam logic signed [12:0] RGT_L   = 13'(OBJECT_WIDTH_X - EDGE_MARGIN);
    localparam logic signed [12:0] BOT_L   = 13'(OBJECT_HIGHT_Y - EDGE_MARGIN);

    typedef enum logic {
        WAIT_SOF_ST,
        COLLECT_ST
    } state_t;

    // Stage-1 input copies
    logic               sof_q;
    logic [10:0]        pix_x_q;
    logic [10:0]        pix_y_q;
    logic signed [10:0] tl_x_q;
    logic signed [10:0] tl_y_q;
    logic               smiley_q;
    logic               brick_q;

    // Frame accumulators and FSM state
    state_t             state_q;
    logic               acc_hit_q;
    logic [3:0]         acc_edge_q;
    logic [CNT_W-1:0]   acc_cnt_q;

    // Combinational hit classification
    logic               hit;
    logic signed [12:0] off_x;
    logic signed [12:0] off_y;
    logic               in_x;
    logic               in_y;
    logic [3:0]         edge_v;
    logic [3:0]         edge_m;
    logic [CNT_W-1:0]   cnt_d;

    // Register the scan inputs one cycle before classification
    always_ff @(posedge clk) begin
        if (reset) begin
            sof_q    <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            tl_x_q   <= '0;
            tl_y_q   <= '0;
            smiley_q <= 1'b0;
            brick_q  <= 1'b0;
        end else begin
            sof_q    <= startOfFrame;
            pix_x_q  <= pixelX;
            pix_y_q  <= pixelY;
            tl_x_q   <= topLeftX;
            tl_y_q   <= topLeftY;
            smiley_q <= smileyDR;
            brick_q  <= brickDR;
        end
    end

    // Hit detection, smiley-relative offsets and edge-band classification
    always_comb begin
        hit = smiley_q & brick_q &
              ({1'b0, pix_x_q} < SCR_W_L) & ({1'b0, pix_y_q} < SCR_H_L);
        // 13-bit offsets so no pixel/top-left combination can wrap
        off_x = $signed({2'b00, pix_x_q}) - $signed({{2{tl_x_q[10]}}, tl_x_q});
        off_y = $signed({2'b00, pix_y_q}) - $signed({{2{tl_y_q[10]}}, tl_y_q});
        in_x  = (off_x >= 13'sd0) && (off_x < OBJ_W_L);
        in_y  = (off_y >= 13'sd0) && (off_y < OBJ_H_L);
        edge_v    = '0;
        edge_v[3] = in_x && (off_x < MARG_L);
        edge_v[1] = in_x && (off_x >= RGT_L);
        edge_v[2] = in_y && (off_y < MARG_L);
        edge_v[0] = in_y && (off_y >= BOT_L);
        edge_m    = hit ? edge_v : 4'b0000;
        // Saturating count including the current pixel; used for both
        // accumulation and publish so the SOF-cycle pixel is not lost
        cnt_d = (hit && (acc_cnt_q != '1)) ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
    end

    // Frame FSM: accumulate hits, publish and clear at each start of frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_SOF_ST;
            acc_hit_q      <= 1'b0;
            acc_edge_q     <= '0;
            acc_cnt_q      <= '0;
            collision      <= 1'b0;
            HitEdgeCode    <= '0;
            hitCount       <= '0;
            collisionPulse <= 1'b0;
        end else begin
            collisionPulse <= 1'b0;
            case (state_q)
                WAIT_SOF_ST: begin
                    acc_hit_q  <= 1'b0;
                    acc_edge_q <= '0;
                    acc_cnt_q  <= '0;
                    if (sof_q) begin
                        state_q <= COLLECT_ST;
                    end
                end
                COLLECT_ST: begin
                    if (sof_q) begin
                        collision      <= acc_hit_q | hit;
                        HitEdgeCode    <= acc_edge_q | edge_m;
                        hitCount       <= cnt_d;
                        collisionPulse <= acc_hit_q | hit;
                        acc_hit_q      <= 1'b0;
                        acc_edge_q     <= '0;
                        acc_cnt_q      <= '0;
                    end else if (hit) begin
                        acc_hit_q  <= 1'b1;
                        acc_edge_q <= acc_edge_q | edge_m;
                        acc_cnt_q  <= cnt_d;
                    end
                end
                default: state_q <= WAIT_SOF_ST;
            endcase
        end
    end

endmodule

// File: tb/tb_smiley_hit_detect.sv
// Bench for smiley_hit_detect: vector table, hand sequences and random frames,
// all checked against a frame-level reference model.
module tb_smiley_hit_detect;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic [10:0]        pixelX;
    logic [10:0]        pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               smileyDR;
    logic               brickDR;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic [CW-1:0]      hitCount;
    logic               collisionPulse;

    int n_cmp = 0;
    int n_bad = 0;

    smiley_hit_detect #(
        .OBJECT_WIDTH_X(64),
        .OBJECT_HIGHT_Y(64),
        .EDGE_MARGIN(4),
        .SCREEN_W(640),
        .SCREEN_H(480),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY),
        .smileyDR(smileyDR),
        .brickDR(brickDR),
        .collision(collision),
        .HitEdgeCode(HitEdgeCode),
        .hitCount(hitCount),
        .collisionPulse(collisionPulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d bad of %0d, need completion", n_bad, n_cmp);
        $fatal(1, "timeout");
    end

    // Reference model state (frame level)
    bit armed = 0;
    bit acc_hit = 0;
    int acc_edge = 0;
    int acc_n = 0;
    bit pend_v = 0;
    int pend_col = 0, pend_edge = 0, pend_cnt = 0;
    int exp_col = 0, exp_edge = 0, exp_cnt = 0, exp_pul = 0;

    function automatic int pk(int col, int edg, int cnt, int pul);
        return ((col & 1) << 9) | ((edg & 15) << 5) | ((cnt & 15) << 1) | (pul & 1);
    endfunction

    function automatic int act_pk();
        return pk(int'(collision), int'(HitEdgeCode), int'(hitCount), int'(collisionPulse));
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got col/edge/cnt/pulse 0x%03h, expected 0x%03h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Screen-level rule: hit when both drawn and on screen; edge bands by offset
    task automatic classify(input int x, input int y, input int tlx, input int tly,
                            input bit sdr, input bit bdr, output bit h, output int e);
        int ox, oy;
        h  = sdr && bdr && (x < 640) && (y < 480);
        ox = x - tlx;
        oy = y - tly;
        e  = 0;
        if (ox >= 0 && ox < 64) begin
            if (ox < 4)   e |= 8;
            if (ox >= 60) e |= 2;
        end
        if (oy >= 0 && oy < 64) begin
            if (oy < 4)   e |= 4;
            if (oy >= 60) e |= 1;
        end
    endtask

    // One clock: drive inputs, advance model, check all outputs after the edge
    task automatic drive(input bit rst, input bit sof, input int x, input int y,
                         input int tlx, input int tly, input bit sdr, input bit bdr);
        logic [10:0]        xv, yv;
        logic signed [10:0] tx, ty;
        bit  h;
        int  e;
        bit  nv = 0;
        int  ncol = 0, nedge = 0, ncnt = 0;
        xv = 11'(x); yv = 11'(y); tx = 11'(tlx); ty = 11'(tly);
        reset = rst; startOfFrame = sof; pixelX = xv; pixelY = yv;
        topLeftX = tx; topLeftY = ty; smileyDR = sdr; brickDR = bdr;
        classify(int'(xv), int'(yv), int'(tx), int'(ty), sdr, bdr, h, e);
        if (!rst) begin
            if (sof) begin
                if (armed) begin
                    nv    = 1;
                    ncol  = int'(acc_hit | h);
                    nedge = acc_edge | (h ? e : 0);
                    ncnt  = (acc_n + int'(h) > MAXC) ? MAXC : acc_n + int'(h);
                end
                armed = 1; acc_hit = 0; acc_edge = 0; acc_n = 0;
            end else if (armed && h) begin
                acc_hit = 1; acc_edge |= e; acc_n++;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            armed = 0; acc_hit = 0; acc_edge = 0; acc_n = 0; pend_v = 0;
            exp_col = 0; exp_edge = 0; exp_cnt = 0; exp_pul = 0;
        end else begin
            if (pend_v) begin
                exp_col = pend_col; exp_edge = pend_edge; exp_cnt = pend_cnt; exp_pul = pend_col;
            end else begin
                exp_pul = 0;
            end
            pend_v = nv; pend_col = ncol; pend_edge = nedge; pend_cnt = ncnt;
        end
        chk("model", act_pk(), pk(exp_col, exp_edge, exp_cnt, exp_pul));
    endtask

    typedef struct {
        bit rst; bit sof; int x; int y; bit dr;
        int col; int edg; int cnt; int pul;
    } vec_t;

    function automatic vec_t mk(bit rst, bit sof, int x, int y, bit dr,
                                int col, int edg, int cnt, int pul);
        vec_t v;
        v.rst = rst; v.sof = sof; v.x = x; v.y = y; v.dr = dr;
        v.col = col; v.edg = edg; v.cnt = cnt; v.pul = pul;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        // topLeft fixed at (100,100); expected outputs are after that row's edge
        tbl[0]  = mk(1, 0,   0,   0, 0,  0, 4'b0000, 0, 0); // reset
        tbl[1]  = mk(0, 1,   0,   0, 0,  0, 4'b0000, 0, 0); // first SOF arms only
        tbl[2]  = mk(0, 0,   0,   0, 0,  0, 4'b0000, 0, 0);
        tbl[3]  = mk(0, 1,   0,   0, 0,  0, 4'b0000, 0, 0);
        tbl[4]  = mk(0, 0,   0,   0, 0,  0, 4'b0000, 0, 0); // empty frame published
        tbl[5]  = mk(0, 0, 100, 150, 1,  0, 4'b0000, 0, 0);
        tbl[6]  = mk(0, 0, 101, 150, 1,  0, 4'b0000, 0, 0);
        tbl[7]  = mk(0, 0, 102, 150, 1,  0, 4'b0000, 0, 0);
        tbl[8]  = mk(0, 0, 103, 150, 1,  0, 4'b0000, 0, 0);
        tbl[9]  = mk(0, 1,   0,   0, 0,  0, 4'b0000, 0, 0);
        tbl[10] = mk(0, 0,   0,   0, 0,  1, 4'b1000, 4, 1); // left band, 4 hits
        tbl[11] = mk(0, 0,   0,   0, 0,  1, 4'b1000, 4, 0);
        tbl[12] = mk(0, 0, 163, 163, 1,  1, 4'b1000, 4, 0);
        tbl[13] = mk(0, 1,   0,   0, 0,  1, 4'b1000, 4, 0);
        tbl[14] = mk(0, 0,   0,   0, 0,  1, 4'b0011, 1, 1); // right+bottom corner
        tbl[15] = mk(0, 0, 130, 130, 1,  1, 4'b0011, 1, 0);
        tbl[16] = mk(0, 1,   0,   0, 0,  1, 4'b0011, 1, 0);
        tbl[17] = mk(0, 0,   0,   0, 0,  1, 4'b0000, 1, 1); // interior hit
        tbl[18] = mk(0, 1,   0,   0, 0,  1, 4'b0000, 1, 0);
        tbl[19] = mk(0, 0,   0,   0, 0,  0, 4'b0000, 0, 0); // clean frame
        tbl[20] = mk(0, 0, 640, 150, 1,  0, 4'b0000, 0, 0); // off-screen ignored
        tbl[21] = mk(0, 1, 103, 103, 1,  0, 4'b0000, 0, 0); // SOF-cycle pixel counts
        tbl[22] = mk(0, 0,   0,   0, 0,  1, 4'b1100, 1, 1);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].sof, tbl[i].x, tbl[i].y, 100, 100, tbl[i].dr, tbl[i].dr);
            chk($sformatf("vec%0d", i), act_pk(), pk(tbl[i].col, tbl[i].edg, tbl[i].cnt, tbl[i].pul));
        end

        // Saturation: 20 interior hits plus off-screen overlap
        for (int i = 0; i < 20; i++) drive(0, 0, 110 + (i % 10), 120, 100, 100, 1, 1);
        drive(0, 0, 640, 120, 100, 100, 1, 1);
        drive(0, 1, 0, 0, 100, 100, 0, 0);
        drive(0, 0, 0, 0, 100, 100, 0, 0);
        chk("saturate", act_pk(), pk(1, 0, 15, 1));

        // Reset mid-frame after hits
        drive(0, 0, 100, 100, 100, 100, 1, 1);
        drive(0, 0, 101, 101, 100, 100, 1, 1);
        drive(1, 0, 0, 0, 100, 100, 0, 0);
        chk("reset_mid", act_pk(), pk(0, 0, 0, 0));
        drive(0, 0, 100, 100, 100, 100, 1, 1);
        drive(0, 1, 100, 100, 100, 100, 1, 1);
        drive(0, 0, 0, 0, 100, 100, 0, 0);
        drive(0, 0, 0, 0, 100, 100, 0, 0);
        chk("rearm_no_pub", act_pk(), pk(0, 0, 0, 0));
        for (int i = 0; i < 3; i++) drive(0, 0, 163, 130 + i, 100, 100, 1, 1);
        drive(0, 1, 0, 0, 100, 100, 0, 0);
        drive(0, 0, 0, 0, 100, 100, 0, 0);
        chk("second_sof_pub", act_pk(), pk(1, 4'b0010, 3, 1));

        // Back-to-back SOFs: empty frame publishes zeros without a pulse
        drive(0, 0, 130, 100, 100, 100, 1, 1);
        drive(0, 1, 0, 0, 100, 100, 0, 0);
        drive(0, 1, 0, 0, 100, 100, 0, 0);
        chk("b2b_first", act_pk(), pk(1, 4'b0100, 1, 1));
        drive(0, 0, 0, 0, 100, 100, 0, 0);
        chk("b2b_empty", act_pk(), pk(0, 0, 0, 0));

        // Random frames against the model
        for (int f = 0; f < 60; f++) begin
            int tlx, tly, len, rst_at;
            tlx    = int'($urandom_range(0, 620)) - 20;
            tly    = int'($urandom_range(0, 460)) - 20;
            len    = int'($urandom_range(2, 30));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 29)) : -1;
            for (int c = 0; c < len; c++) begin
                int x, y;
                x = ($urandom_range(0, 7) == 0) ? 640 + int'($urandom_range(0, 8))
                                                : (tlx + int'($urandom_range(0, 70)) - 3) & 2047;
                y = (tly + int'($urandom_range(0, 70)) - 3) & 2047;
                drive(c == rst_at, 0, x, y, tlx, tly,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            end
            drive(0, 1, (tlx + int'($urandom_range(0, 66))) & 2047,
                  (tly + int'($urandom_range(0, 66))) & 2047, tlx, tly,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
